fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
Multi-cycle instruction fetch and decode stage sitting directly upstream of the register file / ALU datapath.
- Fetches 32-bit RV32I instructions over a valid/ready instruction-memory interface, one request outstanding.
- Decodes R-type and I-type ALU instructions into rs1/rs2/rd/alu_control/reg_write/immediate fields that drive the register file and ALU.
- Supports a PC redirect input for a future branch unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_addr  output  32  fetch address (current PC).
imem_rsp_valid  input  1  response data valid; memory always accepts it, no backpressure.
imem_rsp_data  input  32  instruction word.
redirect_valid  input  1  load new PC, squash in-flight work.
redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0.
dec_valid  output  1  decoded instruction valid.
dec_ready  input  1  downstream consumes decoded instruction.
dec_pc  output  32  PC of decoded instruction.
rs1  output  5  source register 1.
rs2  output  5  source register 2; 0 for I-type.
rd  output  5  destination register.
alu_control  output  4  ALU operation code.
alu_src_imm  output  1  1 = ALU operand b is imm.
imm  output  32  sign-extended I-type immediate; 0 for R-type.
reg_write  output  1  register write enable.
illegal  output  1  unsupported instruction.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=FETCH, drop flag=0.
  - All dec_* outputs and decode fields are 0.
  - imem_req_valid is 0 while rst is high.
- FSM states:
  - FETCH:
    - imem_req_valid = (state==FETCH) && !redirect_valid && !rst; imem_addr=pc.
    - On req handshake, go to WAIT.
  - WAIT:
    - On imem_rsp_valid, register the decoded fields, assert dec_valid, go to OUT.
    - If drop=1 instead: discard the response, clear drop, go to FETCH.
  - OUT:
    - Hold dec_valid and all fields stable until dec_ready.
    - On dec_valid&&dec_ready: pc<=pc+4, go to FETCH.
- Latency and throughput: request accepted at cycle N, response at N+k (k≥1), dec_valid high at N+k+1. Maximum throughput is 1 instruction per 3 cycles.
- Redirect (highest priority after rst):
  - FETCH: pc<=redirect_pc, no request that cycle, stay in FETCH.
  - WAIT: pc<=redirect_pc, drop<=1, stay in WAIT. If rsp_valid arrives in the same cycle, discard it and go to FETCH with drop=0.
  - OUT: pc<=redirect_pc, dec_valid<=0 next cycle, go to FETCH. A coincident dec_ready is still a legal consume by downstream; pc still takes redirect_pc, not pc+4.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Decode (opcode = instr[6:0]):
  - 0110011 R-type: alu_src_imm=0.
    - funct3 000: ADD (funct7=0000000) or SUB (funct7=0100000).
    - funct3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (by funct7), 110 OR, 111 AND.
    - Any other funct7 → illegal.
  - 0010011 I-type: alu_src_imm=1, imm=sext(instr[31:20]), rs2=0.
    - funct3 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI.
    - 001 SLLI requires instr[31:25]=0.
    - 101 SRLI (instr[31:25]=0000000) / SRAI (instr[31:25]=0100000).
  - illegal=1 gives reg_write=0, alu_control=ADD, imm=0. dec_valid is still asserted.
  - rd==0 gives reg_write=0 (illegal stays 0).
- alu_control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- rsp_valid in FETCH or OUT is a protocol violation; ignore it (assertion in bench).

Decomposition:
- Package cpu_pkg: ALU_* 4-bit codes above; OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011; funct3/funct7 constants; FSM state enum (FETCH/WAIT/OUT).
- One combinational sub-module rv_alu_decoder: instr[31:0] in; rs1, rs2, rd, alu_control, alu_src_imm, imm, reg_write, illegal out.
- fetch_decode holds the FSM, PC, drop flag and output register.

Test Plan:
- Reset then fetch: rst 2 cycles, RESET_PC=0, rsp 32'h002081B3 → imem_addr=0; dec: rs1=1, rs2=2, rd=3, alu_control=0000, reg_write=1, alu_src_imm=0, dec_pc=0; next imem_addr=4.
- SUB/ADDI/SRAI sequence: 32'h407302B3, 32'hFFF00093, 32'h40325213 → (rs1=6, rs2=7, rd=5, ctl 0001); (rd=1, imm=32'hFFFF_FFFF, ctl 0000, alu_src_imm=1); (rs1=4, rd=4, imm=3, ctl 0111).
- Backpressure: dec_ready=0 for 5 cycles in OUT → dec_valid and fields stable; no new imem request until consumed.
- Redirect during WAIT: redirect_pc=32'h100 while awaiting response; response 32'h002081B3 arrives 3 cycles later → discarded, no dec_valid; next imem_addr=32'h100.
- Illegal and x0 destination: rsp 32'h00002003 (LW) → illegal=1, reg_write=0, dec_valid=1; rsp 32'h00000033 (ADD x0,x0,x0) → illegal=0, reg_write=0.
- Sync reset mid-OUT: rst=1 while dec_valid=1 → next cycle dec_valid=0, pc=RESET_PC, imem_req_valid=0 while rst held.

Source files
------------

// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : cpu_pkg                                                          |
// | Brief  : Shared encodings for the fetch/decode stage (ALU ops, opcodes).  |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Operation selected by funct3 when funct7 carries no alternate encoding.
  function automatic logic [3:0] alu_base(input logic [2:0] funct3);
    case (funct3)
      F3_ADD_SUB: alu_base = ALU_ADD;
      F3_SLL:     alu_base = ALU_SLL;
      F3_SLT:     alu_base = ALU_SLT;
      F3_SLTU:    alu_base = ALU_SLTU;
      F3_XOR:     alu_base = ALU_XOR;
      F3_SRL_SRA: alu_base = ALU_SRL;
      F3_OR:      alu_base = ALU_OR;
      default:    alu_base = ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_alu_decoder.sv
// +----------------------------------------------------------------------------+
// | Module : rv_alu_decoder                                                   |
// | Brief  : Combinational RV32I R/I-type ALU instruction decoder.            |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv_alu_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_control,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_ok;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  always_comb begin
    w_ok        = 1'b0;
    rs1         = instr[19:15];
    rd          = instr[11:7];
    rs2         = 5'd0;
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    imm         = 32'd0;
    case (w_opcode)
      OPC_OP: begin
        rs2 = instr[24:20];
        if (w_funct7 == F7_BASE) begin
          w_ok        = 1'b1;
          alu_control = alu_base(w_funct3);
        end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD_SUB) begin
          w_ok        = 1'b1;
          alu_control = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == F3_SRL_SRA) begin
          w_ok        = 1'b1;
          alu_control = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        alu_src_imm = 1'b1;
        alu_control = alu_base(w_funct3);
        // Shift immediates carry only the 5-bit shamt; the upper bits are funct7.
        case (w_funct3)
          F3_SLL: begin
            w_ok = (w_funct7 == F7_BASE);
            imm  = {27'd0, instr[24:20]};
          end
          F3_SRL_SRA: begin
            w_ok = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
            imm  = {27'd0, instr[24:20]};
            if (w_funct7 == F7_ALT) alu_control = ALU_SRA;
          end
          default: begin
            w_ok = 1'b1;
            imm  = {{20{instr[31]}}, instr[31:20]};
          end
        endcase
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) begin
      alu_control = ALU_ADD;
      alu_src_imm = 1'b0;
      imm         = 32'd0;
    end
  end

  assign illegal   = !w_ok;
  assign reg_write = w_ok && (rd != 5'd0);

endmodule

`default_nettype wire

// File: rtl/fetch_decode.sv
// +----------------------------------------------------------------------------+
// | Module : fetch_decode                                                     |
// | Brief  : Multi-cycle fetch + decode stage with PC redirect and squash.    |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_decode
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_control,
  output logic        alu_src_imm,
  output logic [31:0] imm,
  output logic        reg_write,
  output logic        illegal
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [31:0] w_target;

  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [3:0]  w_alu_control;
  logic        w_alu_src_imm;
  logic [31:0] w_imm;
  logic        w_reg_write;
  logic        w_illegal;

  rv_alu_decoder u_dec (
    .instr       (imem_rsp_data),
    .rs1         (w_rs1),
    .rs2         (w_rs2),
    .rd          (w_rd),
    .alu_control (w_alu_control),
    .alu_src_imm (w_alu_src_imm),
    .imm         (w_imm),
    .reg_write   (w_reg_write),
    .illegal     (w_illegal)
  );

  assign w_target       = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = (r_state == FETCH) && !redirect_valid && !rst;
  assign imem_addr      = r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      dec_valid   <= 1'b0;
      dec_pc      <= 32'd0;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      alu_control <= 4'd0;
      alu_src_imm <= 1'b0;
      imm         <= 32'd0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_valid) begin
            r_pc <= w_target;
          end else if (imem_req_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            // The outstanding response still has to be drained; a coincident one is it.
            r_pc <= w_target;
            if (imem_rsp_valid) begin
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end else begin
              dec_valid   <= 1'b1;
              dec_pc      <= r_pc;
              rs1         <= w_rs1;
              rs2         <= w_rs2;
              rd          <= w_rd;
              alu_control <= w_alu_control;
              alu_src_imm <= w_alu_src_imm;
              imm         <= w_imm;
              reg_write   <= w_reg_write;
              illegal     <= w_illegal;
              r_state     <= OUT;
            end
          end
        end
        OUT: begin
          if (redirect_valid) begin
            r_pc      <= w_target;
            dec_valid <= 1'b0;
            r_state   <= FETCH;
          end else if (dec_ready) begin
            r_pc      <= r_pc + 32'd4;
            dec_valid <= 1'b0;
            r_state   <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode.sv
// +----------------------------------------------------------------------------+
// | Module : tb_fetch_decode                                                  |
// | Brief  : Self-checking bench for fetch_decode with a behavioural model.   |
// | Rev    : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  // ALU op indexed by funct3 for the plain (funct7 = 0) encodings.
  localparam logic [3:0] OP_BY_F3 [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control;
  logic        alu_src_imm;
  logic [31:0] imm;
  logic        reg_write;
  logic        illegal;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_pc;

  fetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .alu_control    (alu_control),
    .alu_src_imm    (alu_src_imm),
    .imm            (imm),
    .reg_write      (reg_write),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed decode result: {pc, rs1, rs2, rd, alu_control, alu_src_imm, imm, reg_write, illegal}
  function automatic logic [127:0] ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [3:0]  ctl;
    logic        src;
    logic [31:0] iv;
    logic [4:0]  r2;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1'b0; ctl = 4'd0; src = 1'b0; iv = 32'd0; r2 = 5'd0;
    if (op == 7'h33) begin
      r2 = ins[24:20];
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      ctl = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : OP_BY_F3[f3];
    end else if (op == 7'h13) begin
      src = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        iv = 32'(ins[24:20]);
        ctl = (f7 == 7'h20) ? 4'd7 : OP_BY_F3[f3];
      end else begin
        legal = 1'b1;
        iv = 32'($signed(ins[31:20]));
        ctl = OP_BY_F3[f3];
      end
    end
    if (!legal) begin ctl = 4'd0; src = 1'b0; iv = 32'd0; end
    ref_dec = 128'({pc, ins[19:15], r2, ins[11:7], ctl, src, iv,
                    legal && (ins[11:7] != 5'd0), !legal});
  endfunction

  function automatic logic [127:0] dut_dec();
    dut_dec = 128'({dec_pc, rs1, rs2, rd, alu_control, alu_src_imm, imm, reg_write, illegal});
  endfunction

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    check("req_valid", imem_req_valid, 1'b1);
  endtask

  // Request handshake after 'stall' idle cycles, response 'lat' cycles after acceptance.
  task automatic issue(input logic [31:0] ins, input int stall, input int lat);
    wait_req();
    check("imem_addr", imem_addr, exp_pc);
    repeat (stall) @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check("wait_no_valid", dec_valid, 1'b0);
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = ins;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
  endtask

  task automatic check_out(input logic [31:0] ins, input string tag);
    check({tag, "_valid"}, dec_valid, 1'b1);
    check({tag, "_fields"}, dut_dec(), ref_dec(ins, exp_pc));
  endtask

  task automatic consume(input logic [31:0] ins, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", dec_valid, 1'b1);
      check("hold_fields", dut_dec(), ref_dec(ins, exp_pc));
      check("hold_no_req", imem_req_valid, 1'b0);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    check("consumed", dec_valid, 1'b0);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic run_one(input logic [31:0] ins, input string tag);
    issue(ins, 0, 1);
    check_out(ins, tag);
    consume(ins, 0);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    ins[6:0] = (sel < 4) ? 7'h33 : (sel < 8) ? 7'h13 : 7'($urandom);
    sel = $urandom_range(0, 4);
    if (sel < 2) ins[31:25] = 7'h00;
    else if (sel < 4) ins[31:25] = 7'h20;
    return ins;
  endfunction

  initial begin
    logic [31:0] ins;
    exp_pc = RESET_PC;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_low", imem_req_valid, 1'b0);
    check("rst_dec_zero", {dec_valid, dut_dec()}, 129'd0);
    rst = 1'b0;
    #1;

    // Basic fetch: ADD x3, x1, x2
    run_one(32'h002081B3, "add");
    wait_req();
    check("next_addr", imem_addr, 32'd4);

    run_one(32'h407302B3, "sub");
    run_one(32'hFFF00093, "addi");
    run_one(32'h40325213, "srai");

    // Backpressure
    issue(32'h0062E233, 1, 2);
    check_out(32'h0062E233, "or_bp");
    consume(32'h0062E233, 5);

    // Illegal (LW) and x0 destination
    run_one(32'h00002003, "lw_illegal");
    run_one(32'h00000033, "add_x0");

    // Redirect during WAIT: response 3 cycles later must be dropped
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h002081B3;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("drop_no_valid", dec_valid, 1'b0);
    exp_pc = 32'h0000_0100;
    run_one(32'h00A5F533, "after_drop");

    // Redirect coincident with the response in WAIT
    wait_req();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h002081B3;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check("coinc_no_valid", dec_valid, 1'b0);
    exp_pc = 32'h0000_0400;
    run_one(32'h00C5C5B3, "after_coinc");

    // Redirect in FETCH suppresses the request
    wait_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    check("fetch_redir_req", imem_req_valid, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0200;
    run_one(32'h00108113, "after_fetch_redir");

    // Redirect in OUT with coincident dec_ready, then PC wrap
    issue(32'h00209133, 0, 1);
    check_out(32'h00209133, "out_redir");
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    dec_ready      = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    check("out_redir_drop", dec_valid, 1'b0);
    exp_pc = 32'hFFFF_FFFC;
    run_one(32'h00000013, "wrap");
    wait_req();
    check("wrap_addr", imem_addr, 32'd0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      ins = gen_instr();
      issue(ins, $urandom_range(0, 2), $urandom_range(1, 4));
      check_out(ins, "rand");
      consume(ins, $urandom_range(0, 3));
    end

    // Synchronous reset while holding an output
    issue(32'h002081B3, 0, 1);
    check_out(32'h002081B3, "pre_rst");
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", dec_valid, 1'b0);
    check("rst_out_req", imem_req_valid, 1'b0);
    @(negedge clk);
    check("rst_hold_req", imem_req_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_req", imem_req_valid, 1'b1);
    check("post_rst_addr", imem_addr, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
